// File: rtl/itc_genlock_sequencer.sv
// Genlock sequencer: qualifies input timing, arms and gates the sync generator,
// supervises lock through sof/sof_locked and recovers after lock loss via a hold-off.
module itc_genlock_sequencer #(
    parameter int unsigned TIMER_WIDTH    = 24,
    parameter int unsigned STABLE_CYCLES  = 16,
    parameter int unsigned LOCK_TIMEOUT   = 4194304,
    parameter int unsigned SOF_WATCHDOG   = 2097152,
    parameter int unsigned HOLDOFF_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       go,
    input  logic       clr_stats,
    input  logic       stable,
    input  logic       total_sample_count_valid,
    input  logic       total_line_count_valid,
    input  logic       sof,
    input  logic       sof_locked,
    output logic       output_enable,
    output logic       clear_enable,
    output logic       enable_count,
    output logic       locked,
    output logic [2:0] state,
    output logic [7:0] lost_count
);

    typedef enum logic [2:0] {
        StIdle       = 3'd0,
        StWaitStable = 3'd1,
        StArm        = 3'd2,
        StAcquire    = 3'd3,
        StLocked     = 3'd4,
        StHoldoff    = 3'd5
    } state_e;

    localparam logic [TIMER_WIDTH-1:0] TimerMax   = '1;
    localparam logic [TIMER_WIDTH-1:0] StableLast = TIMER_WIDTH'(STABLE_CYCLES - 1);
    localparam logic [TIMER_WIDTH-1:0] LockLast   = TIMER_WIDTH'(LOCK_TIMEOUT - 1);
    localparam logic [TIMER_WIDTH-1:0] WdogLast   = TIMER_WIDTH'(SOF_WATCHDOG - 1);
    localparam logic [TIMER_WIDTH-1:0] HoldLast   = TIMER_WIDTH'(HOLDOFF_CYCLES - 1);

    state_e                 state_q, state_d;
    logic [TIMER_WIDTH-1:0] timer_q, timer_d;
    logic [7:0]             lost_q, lost_d;
    logic                   lost_inc;
    logic                   qual;

    assign qual = stable & total_sample_count_valid & total_line_count_valid;

    always_comb begin
        state_d  = state_q;
        timer_d  = (timer_q == TimerMax) ? timer_q : timer_q + 1'b1;
        lost_inc = 1'b0;
        case (state_q)
            StIdle: begin
                timer_d = '0;
                if (go) state_d = StWaitStable;
            end
            StWaitStable: begin
                if (!qual) timer_d = '0;
                else if (timer_q == StableLast) state_d = StArm;
            end
            StArm: state_d = StAcquire;
            StAcquire: begin
                if (sof && sof_locked) begin
                    state_d = StLocked;
                end else if (!qual) begin
                    state_d = StWaitStable;
                end else if (timer_q == LockLast) begin
                    state_d  = StHoldoff;
                    lost_inc = 1'b1;
                end
            end
            StLocked: begin
                if (sof) timer_d = '0;
                if (!sof_locked || !qual || timer_q == WdogLast) begin
                    state_d  = StHoldoff;
                    lost_inc = 1'b1;
                end
            end
            StHoldoff: begin
                if (timer_q == HoldLast) state_d = StWaitStable;
            end
            default: state_d = StIdle;
        endcase
        // Host disable overrides everything and is not counted as a lock loss.
        if (!go) begin
            state_d  = StIdle;
            lost_inc = 1'b0;
        end
        if (state_d != state_q) timer_d = '0;
    end

    always_comb begin
        lost_d = lost_q;
        if (clr_stats) lost_d = '0;
        else if (lost_inc && lost_q != 8'hff) lost_d = lost_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            timer_q <= '0;
            lost_q  <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            lost_q  <= lost_d;
        end
    end

    always_comb begin
        clear_enable  = (state_q == StArm);
        output_enable = (state_q == StAcquire) || (state_q == StLocked);
        enable_count  = output_enable;
        locked        = (state_q == StLocked);
    end

    assign state      = state_q;
    assign lost_count = lost_q;

endmodule

// File: tb/tb_itc_genlock_sequencer.sv
// Directed bench for itc_genlock_sequencer with short timing parameters.
module tb_itc_genlock_sequencer;

    logic       clk = 1'b0;
    logic       rst_n, go, clr_stats, stable, tscv, tlcv, sof, sof_locked;
    logic       output_enable, clear_enable, enable_count, locked;
    logic [2:0] state;
    logic [7:0] lost_count;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_lost = 0;

    itc_genlock_sequencer #(
        .TIMER_WIDTH   (24),
        .STABLE_CYCLES (4),
        .LOCK_TIMEOUT  (64),
        .SOF_WATCHDOG  (32),
        .HOLDOFF_CYCLES(8)
    ) dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .go                      (go),
        .clr_stats               (clr_stats),
        .stable                  (stable),
        .total_sample_count_valid(tscv),
        .total_line_count_valid  (tlcv),
        .sof                     (sof),
        .sof_locked              (sof_locked),
        .output_enable           (output_enable),
        .clear_enable            (clear_enable),
        .enable_count            (enable_count),
        .locked                  (locked),
        .state                   (state),
        .lost_count              (lost_count)
    );

    always #5 clk = ~clk;

    // Advance n rising edges; inputs and checks happen 1 ns after the edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; go = 1'b0; clr_stats = 1'b0; stable = 1'b0; tscv = 1'b0; tlcv = 1'b0;
        sof = 1'b0; sof_locked = 1'b0;
        step(2);
        n_checks++; if (state !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", state); end
        n_checks++; if ({output_enable, clear_enable, enable_count, locked} !== 4'b0) begin
            n_fail++; $display("FAIL reset_outputs: got %b want 0000",
                                {output_enable, clear_enable, enable_count, locked}); end
        n_checks++; if (lost_count !== 8'd0) begin n_fail++; $display("FAIL reset_lost: got %0d want 0", lost_count); end
        rst_n = 1'b1;
        step(1);
        n_checks++; if (state !== 3'd0) begin n_fail++; $display("FAIL idle_no_go: got %0d want 0", state); end
    endtask

    task automatic test_startup();
        stable = 1'b1; tscv = 1'b1; tlcv = 1'b1; sof_locked = 1'b1; go = 1'b1;  // cycle 0
        step(1);
        n_checks++; if (state !== 3'd1) begin n_fail++; $display("FAIL start_ws: got %0d want 1", state); end
        step(3);
        n_checks++; if (state !== 3'd1 || clear_enable !== 1'b0) begin n_fail++;
            $display("FAIL start_c4: state=%0d clr=%b want 1/0", state, clear_enable); end
        step(1);
        n_checks++; if (state !== 3'd2 || clear_enable !== 1'b1 || output_enable !== 1'b0) begin n_fail++;
            $display("FAIL start_arm: state=%0d clr=%b oe=%b want 2/1/0", state, clear_enable, output_enable); end
        step(1);
        n_checks++; if (state !== 3'd3 || clear_enable !== 1'b0 || output_enable !== 1'b1 ||
                        enable_count !== 1'b1 || locked !== 1'b0) begin n_fail++;
            $display("FAIL start_acq: state=%0d clr=%b oe=%b ec=%b lk=%b want 3/0/1/1/0",
                     state, clear_enable, output_enable, enable_count, locked); end
        sof = 1'b1;
        step(1);
        sof = 1'b0;
        n_checks++; if (state !== 3'd4 || locked !== 1'b1 || output_enable !== 1'b1) begin n_fail++;
            $display("FAIL start_lock: state=%0d lk=%b oe=%b want 4/1/1", state, locked, output_enable); end
    endtask

    task automatic test_qual_drop();
        go = 1'b0;
        step(1);
        n_checks++; if (state !== 3'd0 || lost_count !== 8'd0) begin n_fail++;
            $display("FAIL go_off_locked: state=%0d lost=%0d want 0/0", state, lost_count); end
        go = 1'b1;
        step(1);                          // WAIT_STABLE, qualified cycles 1..3
        step(3);
        stable = 1'b0;                    // cycle 4 unqualified
        step(1);
        stable = 1'b1;
        n_checks++; if (state !== 3'd1) begin n_fail++; $display("FAIL qdrop_hold: got %0d want 1", state); end
        step(3);
        n_checks++; if (state !== 3'd1) begin n_fail++; $display("FAIL qdrop_restart: got %0d want 1", state); end
        step(1);
        n_checks++; if (state !== 3'd2) begin n_fail++; $display("FAIL qdrop_arm: got %0d want 2", state); end
        sof_locked = 1'b0;
        step(1);
        n_checks++; if (state !== 3'd3) begin n_fail++; $display("FAIL qdrop_acq: got %0d want 3", state); end
    endtask

    task automatic test_lock_timeout();
        step(63);
        n_checks++; if (state !== 3'd3 || output_enable !== 1'b1) begin n_fail++;
            $display("FAIL to_last_acq: state=%0d oe=%b want 3/1", state, output_enable); end
        step(1);
        exp_lost = 1;
        n_checks++; if (state !== 3'd5 || output_enable !== 1'b0 || lost_count !== 8'(exp_lost)) begin n_fail++;
            $display("FAIL to_holdoff: state=%0d oe=%b lost=%0d want 5/0/%0d", state, output_enable,
                     lost_count, exp_lost); end
        step(7);
        n_checks++; if (state !== 3'd5) begin n_fail++; $display("FAIL to_hold_end: got %0d want 5", state); end
        step(1);
        n_checks++; if (state !== 3'd1) begin n_fail++; $display("FAIL to_rewait: got %0d want 1", state); end
        sof_locked = 1'b1;
    endtask

    task automatic test_watchdog();
        step(5);
        sof = 1'b1;
        step(1);
        sof = 1'b0;
        n_checks++; if (state !== 3'd4) begin n_fail++; $display("FAIL wd_lock: got %0d want 4", state); end
        for (int i = 0; i < 3; i++) begin
            step(19);
            n_checks++; if (state !== 3'd4 || locked !== 1'b1) begin n_fail++;
                $display("FAIL wd_keep%0d: state=%0d lk=%b want 4/1", i, state, locked); end
            sof = 1'b1;
            step(1);
            sof = 1'b0;
        end
        step(31);
        n_checks++; if (state !== 3'd4) begin n_fail++; $display("FAIL wd_edge: got %0d want 4", state); end
        step(1);
        exp_lost++;
        n_checks++; if (state !== 3'd5 || lost_count !== 8'(exp_lost)) begin n_fail++;
            $display("FAIL wd_expire: state=%0d lost=%0d want 5/%0d", state, lost_count, exp_lost); end
        step(8);
        n_checks++; if (state !== 3'd1) begin n_fail++; $display("FAIL wd_rewait: got %0d want 1", state); end
        step(5);
        sof = 1'b1;
        step(1);
        sof = 1'b0;
        step(5);
        sof_locked = 1'b0;
        step(1);
        sof_locked = 1'b1;
        exp_lost++;
        n_checks++; if (state !== 3'd5 || output_enable !== 1'b0 || lost_count !== 8'(exp_lost)) begin n_fail++;
            $display("FAIL sl_drop: state=%0d oe=%b lost=%0d want 5/0/%0d", state, output_enable,
                     lost_count, exp_lost); end
        step(8);
    endtask

    // From the first WAIT_STABLE cycle: lock, then lose it via sof_locked; ends in WAIT_STABLE.
    task automatic lose_once(input logic clr);
        step(5);
        sof = 1'b1;
        step(1);
        sof = 1'b0;
        sof_locked = 1'b0;
        clr_stats = clr;
        step(1);
        sof_locked = 1'b1;
        clr_stats = 1'b0;
        step(8);
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 297; i++) begin
            lose_once(1'b0);
            exp_lost = (exp_lost < 255) ? exp_lost + 1 : 255;
            n_checks++; if (lost_count !== 8'(exp_lost)) begin n_fail++;
                $display("FAIL sat_iter%0d: lost=%0d want %0d", i, lost_count, exp_lost); end
        end
        n_checks++; if (lost_count !== 8'd255) begin n_fail++; $display("FAIL sat_final: got %0d want 255", lost_count); end
        lose_once(1'b1);
        n_checks++; if (lost_count !== 8'd0 || state !== 3'd1) begin n_fail++;
            $display("FAIL clr_win: lost=%0d state=%0d want 0/1", lost_count, state); end
        lose_once(1'b0);
        n_checks++; if (lost_count !== 8'd1) begin n_fail++; $display("FAIL post_clr: got %0d want 1", lost_count); end
        step(5);
        sof = 1'b1;
        step(1);
        sof = 1'b0;
        go = 1'b0;
        sof_locked = 1'b0;
        step(1);
        n_checks++; if (state !== 3'd0 || lost_count !== 8'd1) begin n_fail++;
            $display("FAIL go_vs_loss: state=%0d lost=%0d want 0/1", state, lost_count); end
        sof_locked = 1'b1;
    endtask

    task automatic test_reset_mid();
        go = 1'b1;
        step(1);
        step(5);
        sof = 1'b1;
        step(1);
        sof = 1'b0;
        n_checks++; if (state !== 3'd4 || output_enable !== 1'b1) begin n_fail++;
            $display("FAIL rm_pre: state=%0d oe=%b want 4/1", state, output_enable); end
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        n_checks++; if (state !== 3'd0 || lost_count !== 8'd0 ||
                        {output_enable, clear_enable, enable_count, locked} !== 4'b0) begin n_fail++;
            $display("FAIL rm_reset: state=%0d lost=%0d outs=%b want 0/0/0000", state, lost_count,
                     {output_enable, clear_enable, enable_count, locked}); end
        step(1);
        n_checks++; if (state !== 3'd1) begin n_fail++; $display("FAIL rm_release: got %0d want 1", state); end
    endtask

    initial begin
        test_reset();
        test_startup();
        test_qual_drop();
        test_lock_timeout();
        test_watchdog();
        test_saturation();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/itc_genlock_sequencer.md
# itc_genlock_sequencer

Sequencing controller for the clocked-video-output sync generation block: qualifies the incoming timing (stable, sample/line totals valid), arms the sync generator with a clear pulse, gates its counting and output, and supervises lock through the returned `sof`/`sof_locked` signals. On loss of lock it tears down the output, holds off, and re-acquires. It sits between the host control register bank and the sync generation block.

## Interface
Parameters:
- `TIMER_WIDTH`, 24: width of the shared internal timer.
- `STABLE_CYCLES`, 16: consecutive qualified cycles required before arming (≥1).
- `LOCK_TIMEOUT`, 4194304: maximum ACQUIRE duration in cycles (≥1).
- `SOF_WATCHDOG`, 2097152: maximum cycles between `sof` pulses in LOCKED (≥1).
- `HOLDOFF_CYCLES`, 1024: teardown hold-off after lock loss (≥1).

Ports:
- `clk`  in  1  sole clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `go`  in  1  host genlock enable, level.
- `clr_stats`  in  1  one-cycle pulse; clears `lost_count`.
- `stable`  in  1  input timing stable.
- `total_sample_count_valid`  in  1  sample total measured.
- `total_line_count_valid`  in  1  line total measured.
- `sof`  in  1  start-of-frame pulse from sync generator.
- `sof_locked`  in  1  sync generator lock flag.
- `output_enable`  out  1  to sync generator.
- `clear_enable`  out  1  one-cycle arm pulse to sync generator.
- `enable_count`  out  1  count gate to sync generator.
- `locked`  out  1  status: in LOCKED.
- `state`  out  3  current state encoding.
- `lost_count`  out  8  saturating lock-loss counter.

## Operation
- `qual` = `stable & total_sample_count_valid & total_line_count_valid`.
- One `TIMER_WIDTH`-bit timer, zeroed on every state transition; saturates at all-ones.
- States (encoding): IDLE=0, WAIT_STABLE=1, ARM=2, ACQUIRE=3, LOCKED=4, HOLDOFF=5; 6,7 illegal → IDLE next cycle.
- `go`=0 in any state → IDLE next cycle; highest priority; no `lost_count` increment.
- IDLE: `go`=1 → WAIT_STABLE.
- WAIT_STABLE: `qual`=0 zeroes timer; else timer increments; `qual`=1 with timer == `STABLE_CYCLES`-1 → ARM.
- ARM: exactly one cycle, unconditionally → ACQUIRE.
- ACQUIRE: timer increments; `sof`=1 and `sof_locked`=1 in the same cycle → LOCKED; else `qual`=0 → WAIT_STABLE (no increment); else timer == `LOCK_TIMEOUT`-1 → HOLDOFF, increment.
- LOCKED: timer zeroed on each `sof`, else increments; `sof_locked`=0 or `qual`=0 or timer == `SOF_WATCHDOG`-1 → HOLDOFF, increment.
- HOLDOFF: timer == `HOLDOFF_CYCLES`-1 → WAIT_STABLE.
- Increment means `lost_count` +1, saturating at 255. `clr_stats` wins over a same-cycle increment, resulting in 0. `go` does not clear it.
- Moore outputs decoded from the registered state:
  - `clear_enable`=1 only in ARM.
  - `output_enable`=`enable_count`=1 in ACQUIRE and LOCKED.
  - `locked`=1 only in LOCKED.
  - `state` equals the state register.

## Timing
- Reset (`rst_n`=0 at a `clk` edge):
  - state=IDLE, timer=0, `lost_count`=0.
  - All outputs 0.
  - Reset mid-operation drops `output_enable` on that edge.
- Input condition sampled at edge N → state, and outputs, change at edge N+1. No combinational input-to-output paths.
- Minimum `go`→`output_enable`: `go` at edge 0 → WAIT_STABLE at 1 → ARM at 1+`STABLE_CYCLES` → ACQUIRE at 2+`STABLE_CYCLES`.
- `clear_enable` is high for exactly one cycle, immediately preceding the first `output_enable` cycle.
- Lock-loss detection to `output_enable`=0: one cycle.

## Test plan
1. `STABLE_CYCLES`=4; `go`=1 at cycle 0 with `qual`=1 throughout → `state` goes 1 at cycle 1, 2 at cycle 5, 3 at cycle 6. `clear_enable` is high only at cycle 5; `output_enable` is high from cycle 6. Then `sof` with `sof_locked`=1 → `locked`=1 the next cycle.
2. In WAIT_STABLE, drop `stable` for one cycle after 3 qualified cycles → timer restarts; ARM only after 4 further consecutive qualified cycles.
3. `LOCK_TIMEOUT`=64, `HOLDOFF_CYCLES`=8, no `sof` → HOLDOFF after 64 ACQUIRE cycles with `lost_count`=1, `output_enable`=0; WAIT_STABLE 8 cycles later.
4. `SOF_WATCHDOG`=32; in LOCKED, `sof` every 20 cycles keeps `locked`=1. Stop `sof` → HOLDOFF 32 cycles after the last `sof`. `sof_locked` deasserting instead → HOLDOFF the next cycle.
5. Force 300 lock losses → `lost_count` saturates at 255. `clr_stats` coincident with a loss → 0. `go`=0 together with `sof_locked`=0 in LOCKED → IDLE, no increment.
6. `rst_n`=0 for one cycle while in LOCKED → all outputs 0, `state`=0, `lost_count`=0 on the next edge; `go` still high → WAIT_STABLE one cycle after reset release.
